// File: rtl/da_line_feeder.sv
// Line-buffer transmitter for a D-A converter. The host loads one line of samples,
// then the block emits a converter reset pulse and streams the line, optionally repeating.
module da_line_feeder #(
   parameter int LINENUM = 910,
   parameter int AW      = 10
) (
   input  logic          dack_i,
   input  logic          reset_i,
   input  logic          start_i,
   input  logic          repeat_i,
   input  logic          hold_i,
   input  logic          ld_we_i,
   input  logic [AW-1:0] ld_addr_i,
   input  logic [7:0]    ld_din_i,
   output logic          da_rst_o,
   output logic          we_o,
   output logic [7:0]    din_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          ld_err_o
);

   typedef enum logic [1:0] {IDLE, SYNC, SEND, DONE} state_t;

   localparam logic [AW-1:0] LAST = AW'(LINENUM - 1);
   localparam logic [AW:0]   LN   = (AW+1)'(LINENUM);

   state_t          state_q, state_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic            da_rst_q, da_rst_d;
   logic            we_q, we_d;
   logic [7:0]      din_q, din_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ld_err_q, ld_err_d;
   logic            ld_ok;
   logic [7:0]      mem_q [LINENUM];

   // Loads are only accepted while nothing is being read out of the buffer.
   assign ld_ok = ld_we_i && !reset_i && (state_q == IDLE || state_q == DONE)
                  && ({1'b0, ld_addr_i} < LN);

   always_ff @(posedge dack_i) begin
      if (ld_ok) mem_q[ld_addr_i] <= ld_din_i;
   end

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      da_rst_d  = 1'b0;
      we_d      = 1'b0;
      din_d     = din_q;
      done_d    = 1'b0;
      ld_err_d  = ld_we_i && !ld_ok;
      case (state_q)
         IDLE: if (start_i) state_d = SYNC;
         SYNC: begin
            da_rst_d  = 1'b1;
            rd_addr_d = '0;
            state_d   = SEND;
         end
         SEND: if (!hold_i) begin
            we_d  = 1'b1;
            din_d = mem_q[rd_addr_q];
            // Park on the last address rather than wrapping past the line end.
            if (rd_addr_q == LAST) state_d = DONE;
            else                   rd_addr_d = rd_addr_q + 1'b1;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = repeat_i ? SYNC : IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge dack_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         rd_addr_q <= '0;
         da_rst_q  <= 1'b0;
         we_q      <= 1'b0;
         din_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ld_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         da_rst_q  <= da_rst_d;
         we_q      <= we_d;
         din_q     <= din_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ld_err_q  <= ld_err_d;
      end
   end

   assign da_rst_o = da_rst_q;
   assign we_o     = we_q;
   assign din_o    = din_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign ld_err_o = ld_err_q;

endmodule
